// File: rtl/sata_crc_check.sv
// Receive-side SATA link CRC checker: verifies the trailing CRC dword of each FIS,
// forwards the payload one dword late with the CRC stripped, and reports frame status.
module sata_crc_check #(
  parameter int unsigned DATA_BYTE_WIDTH = 4,
  parameter logic [31:0] CRC_INIT        = 32'h52325032,
  parameter int unsigned MAX_DWORDS      = 2049,
  parameter int unsigned CNT_W           = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_val,
  input  logic [DATA_BYTE_WIDTH*8-1:0] in_data,
  input  logic                         in_sof,
  input  logic                         in_eof,
  input  logic                         in_abort,
  output logic                         out_val,
  output logic [DATA_BYTE_WIDTH*8-1:0] out_data,
  output logic                         out_sof,
  output logic                         out_last,
  output logic                         done,
  output logic                         crc_err,
  output logic                         len_err,
  output logic                         abort_err,
  output logic [CNT_W-1:0]             frame_len
);

  localparam logic [31:0]      CRC_POLY = 32'h04C11DB7;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_DWORDS);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t                         state;
  logic [31:0]                    crc;
  logic [DATA_BYTE_WIDTH*8-1:0]   hold_data;
  logic                           hold_sof;
  logic                           hold_valid;
  logic [CNT_W-1:0]               cnt;
  logic [CNT_W-1:0]               cnt_inc;
  logic                           len_flag;
  logic [31:0]                    crc_seeded;
  logic [31:0]                    crc_stepped;

  // One CRC step: (crc ^ data) * x^32 mod P, unrolled as 32 MSB-first shifts.
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c ^ d;
    for (int unsigned i = 0; i < 32; i++) begin
      r = r[31] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    end
    return r;
  endfunction

  always_comb begin
    cnt_inc     = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    crc_seeded  = crc_next(CRC_INIT, in_data);
    crc_stepped = crc_next(crc, in_data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      crc        <= CRC_INIT;
      hold_data  <= '0;
      hold_sof   <= 1'b0;
      hold_valid <= 1'b0;
      cnt        <= '0;
      len_flag   <= 1'b0;
      out_val    <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      out_last   <= 1'b0;
      done       <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      abort_err  <= 1'b0;
      frame_len  <= '0;
    end else begin
      out_val   <= 1'b0;
      out_sof   <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      crc_err   <= 1'b0;
      len_err   <= 1'b0;
      abort_err <= 1'b0;

      case (state)
        IDLE: begin
          if (in_val && in_sof) begin
            if (in_eof) begin
              done      <= 1'b1;
              len_err   <= 1'b1;
              frame_len <= '0;
            end else begin
              state      <= FRAME;
              crc        <= crc_seeded;
              hold_data  <= in_data;
              hold_sof   <= 1'b1;
              hold_valid <= 1'b1;
              cnt        <= CNT_W'(1);
              len_flag   <= 1'b0;
            end
          end
        end

        FRAME: begin
          if (in_abort || (in_val && (in_sof || in_eof))) begin
            // Any frame termination flushes the held dword as the last payload dword.
            out_val   <= hold_valid;
            out_data  <= hold_data;
            out_sof   <= hold_sof;
            out_last  <= 1'b1;
            done      <= 1'b1;
            len_err   <= len_flag;
            frame_len <= cnt;
            if (!in_abort && in_sof && !in_eof) begin
              abort_err  <= 1'b1;
              crc        <= crc_seeded;
              hold_data  <= in_data;
              hold_sof   <= 1'b1;
              hold_valid <= 1'b1;
              cnt        <= CNT_W'(1);
              len_flag   <= 1'b0;
            end else begin
              abort_err  <= in_abort || in_sof;
              crc_err    <= !in_abort && !in_sof && (in_data != crc);
              state      <= IDLE;
              crc        <= CRC_INIT;
              hold_sof   <= 1'b0;
              hold_valid <= 1'b0;
            end
          end else if (in_val) begin
            out_val   <= hold_valid;
            out_data  <= hold_data;
            out_sof   <= hold_sof;
            hold_data <= in_data;
            hold_sof  <= 1'b0;
            crc       <= crc_stepped;
            cnt       <= cnt_inc;
            if (cnt_inc > MAX_CNT) begin
              len_flag <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sata_crc_check.sv
// Randomised frame-level bench for sata_crc_check with a polynomial-division CRC model
// and expected payload/status queues compared against what the outputs actually carried.
module tb_sata_crc_check;

  localparam int unsigned MAXD    = 2049;
  localparam int          K_GOOD  = 0;
  localparam int          K_BAD   = 1;
  localparam int          K_ABORT = 2;
  localparam int          K_PRESOF = 3;
  localparam logic [31:0] SEED    = 32'h52325032;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_val = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_sof = 1'b0;
  logic        in_eof = 1'b0;
  logic        in_abort = 1'b0;
  logic        out_val;
  logic [31:0] out_data;
  logic        out_sof;
  logic        out_last;
  logic        done;
  logic        crc_err;
  logic        len_err;
  logic        abort_err;
  logic [11:0] frame_len;

  int n_chk = 0;
  int n_err = 0;
  logic in_frame = 1'b0;

  logic [31:0] pl[$];
  logic [33:0] exp_b[$];
  logic [33:0] obs_b[$];
  logic [14:0] exp_s[$];
  logic [14:0] obs_s[$];

  sata_crc_check #(
    .DATA_BYTE_WIDTH(4),
    .CRC_INIT(SEED),
    .MAX_DWORDS(MAXD),
    .CNT_W(12)
  ) dut (
    .clk(clk), .rst(rst),
    .in_val(in_val), .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof), .in_abort(in_abort),
    .out_val(out_val), .out_data(out_data), .out_sof(out_sof), .out_last(out_last),
    .done(done), .crc_err(crc_err), .len_err(len_err), .abort_err(abort_err),
    .frame_len(frame_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // b * x^32 mod (x^32 + P) by long division.
  function automatic logic [31:0] mod_p(input logic [31:0] b);
    logic [63:0] v;
    v = {b, 32'h0};
    for (int i = 63; i >= 32; i--) begin
      if (v[i]) v = v ^ (64'h1_04C1_1DB7 << (i - 32));
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_crc();
    logic [31:0] c;
    c = SEED;
    foreach (pl[i]) c = mod_p(c ^ pl[i]);
    return c;
  endfunction

  function automatic logic [14:0] st(input logic c, input logic l, input logic a, input int unsigned n);
    logic [11:0] fl;
    fl = (n > 4095) ? 12'hFFF : 12'(n);
    return {c, l, a, fl};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (out_val) begin
        obs_b.push_back({out_sof, out_last, out_data});
        check("last_eq_done", out_last, done);
      end
      if (done) begin
        obs_s.push_back({crc_err, len_err, abort_err, frame_len});
        if (frame_len != 0) check("val_with_done", out_val, 1);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic e, input logic a);
    in_val = v; in_data = d; in_sof = s; in_eof = e; in_abort = a;
    @(posedge clk);
    #1;
    in_val = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_abort = 1'b0;
  endtask

  task automatic gap_frame(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, $urandom, rb(), rb(), 1'b0);
  endtask

  task automatic gap_idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(rb(), $urandom, 1'b0, rb(), rb());
  endtask

  task automatic exp_beats();
    for (int i = 0; i < pl.size(); i++)
      exp_b.push_back({i == 0, i == pl.size() - 1, pl[i]});
  endtask

  task automatic send_frame(input int kind, input int unsigned max_gap);
    logic [31:0] c;
    int unsigned n;
    n = pl.size();
    c = ref_crc();
    for (int i = 0; i < n; i++) begin
      drive(1'b1, pl[i], i == 0, 1'b0, 1'b0);
      gap_frame($urandom_range(0, max_gap));
    end
    case (kind)
      K_GOOD:  drive(1'b1, c, 1'b0, 1'b1, 1'b0);
      K_BAD:   drive(1'b1, c ^ (32'h1 << $urandom_range(0, 31)), 1'b0, 1'b1, 1'b0);
      K_ABORT: drive(rb(), $urandom, rb(), rb(), 1'b1);
      default: ;
    endcase
    exp_beats();
    exp_s.push_back(st(kind == K_BAD, n > MAXD, kind >= K_ABORT, n));
    in_frame = (kind == K_PRESOF);
  endtask

  task automatic send_empty();
    drive(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
    check("empty_done", done, 1);
    check("empty_len_err", len_err, 1);
    check("empty_no_val", out_val, 0);
    exp_s.push_back(st(1'b0, 1'b1, 1'b0, 0));
  endtask

  task automatic fill(input int unsigned n);
    pl.delete();
    for (int unsigned i = 0; i < n; i++) pl.push_back($urandom);
  endtask

  task automatic compare_all(input string tag);
    gap_frame(3);
    check({tag, "_beats"}, obs_b.size(), exp_b.size());
    while (exp_b.size() > 0 && obs_b.size() > 0) check({tag, "_beat"}, obs_b.pop_front(), exp_b.pop_front());
    check({tag, "_stats"}, obs_s.size(), exp_s.size());
    while (exp_s.size() > 0 && obs_s.size() > 0) check({tag, "_stat"}, obs_s.pop_front(), exp_s.pop_front());
    exp_b.delete(); obs_b.delete(); exp_s.delete(); obs_s.delete();
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("reset_outs", {out_val, out_data, out_sof, out_last, done, crc_err, len_err, abort_err, frame_len}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single-dword payload whose CRC is zero.
    pl = {SEED};
    drive(1'b1, SEED, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    check("t1_done", done, 1);
    check("t1_last", out_last, 1);
    check("t1_sof", out_sof, 1);
    check("t1_data", out_data, SEED);
    check("t1_crc_err", crc_err, 0);
    check("t1_len", frame_len, 1);
    exp_beats();
    exp_s.push_back(st(1'b0, 1'b0, 1'b0, 1));
    compare_all("t1");

    // Three-dword zero-CRC payload with idle gaps.
    pl = {SEED, 32'h0, 32'h0};
    drive(1'b1, SEED, 1'b1, 1'b0, 1'b0); gap_frame(2);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0); gap_frame(1);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0); gap_frame(3);
    drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    check("t2_done", done, 1);
    exp_beats();
    exp_s.push_back(st(1'b0, 1'b0, 1'b0, 3));
    compare_all("t2");

    // Bad CRC, then a good frame to show the seed is reloaded.
    pl = {SEED};
    drive(1'b1, SEED, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h1, 1'b0, 1'b1, 1'b0);
    check("t3_crc_err", crc_err, 1);
    exp_beats();
    exp_s.push_back(st(1'b1, 1'b0, 1'b0, 1));
    pl = {SEED};
    drive(1'b1, SEED, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    check("t3_reload", crc_err, 0);
    exp_beats();
    exp_s.push_back(st(1'b0, 1'b0, 1'b0, 1));
    compare_all("t3");

    // Abort, then premature sof, then a good frame.
    fill(3); send_frame(K_ABORT, 1);
    check("t4_abort", abort_err, 1);
    fill(3); send_frame(K_PRESOF, 1);
    fill(4); send_frame(K_GOOD, 1);
    check("t4_after_ok", crc_err, 0);
    compare_all("t4");

    // Length boundaries.
    send_empty();
    fill(MAXD); send_frame(K_GOOD, 0);
    fill(MAXD + 1); send_frame(K_GOOD, 0);
    check("t5_len_err", len_err, 1);
    fill(4100); send_frame(K_GOOD, 0);
    check("t5_sat", frame_len, 12'hFFF);
    compare_all("t5");

    // Asynchronous reset mid-frame.
    drive(1'b1, SEED, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h1234, 1'b0, 1'b0, 1'b0);
    check("t6_pre_val", out_val, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_outs", {out_val, out_data, out_sof, out_last, done, crc_err, len_err, abort_err, frame_len}, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    pl = {SEED};
    drive(1'b1, SEED, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    exp_beats();
    exp_s.push_back(st(1'b0, 1'b0, 1'b0, 1));
    compare_all("t6");

    // Random mix of frame endings and inter-frame noise.
    in_frame = 1'b0;
    for (int f = 0; f < 60; f++) begin
      int kind;
      if (!in_frame) gap_idle($urandom_range(0, 3));
      kind = (f == 59) ? K_GOOD : int'($urandom_range(0, in_frame ? 3 : 4));
      if (kind == 4) begin
        send_empty();
      end else begin
        fill($urandom_range(1, 6));
        send_frame(kind, 2);
      end
    end
    compare_all("rnd");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
